// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed N-digit seven-segment scanner with a double-buffered digit bank,
// inter-digit blanking gap and optional leading-zero blanking.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int IDX_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lzb_en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              hex_digit,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic [IDX_W-1:0]        scan_idx,
  output logic                    frame_done
);
  localparam int MAXC = ON_CYCLES > BLANK_CYCLES ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] ON_LAST = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ON, BLANK} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IDX_W-1:0]        idx_n, idx_inc;
  logic [4*NUM_DIGITS-1:0] active, active_n, shadow;
  logic                    pending, accept, copy, wrap, blanked;

  always_comb begin
    idx_inc = scan_idx == IDX_LAST ? '0 : scan_idx + 1'b1;
    state_n = state;
    idx_n = scan_idx;
    cnt_n = cnt + 1'b1;
    wrap = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      idx_n = '0;
      cnt_n = '0;
    end else if (state == IDLE) begin
      state_n = ON;
      cnt_n = '0;
    end else if (state == ON && cnt == ON_LAST) begin
      cnt_n = '0;
      if (BLANK_CYCLES > 0) state_n = BLANK;
      else begin
        idx_n = idx_inc;
        wrap = idx_inc == '0;
      end
    end else if (state == BLANK && cnt == BLANK_LAST) begin
      state_n = ON;
      cnt_n = '0;
      idx_n = idx_inc;
      wrap = idx_inc == '0;
    end
    accept = load_valid && load_ready;
    // shadow only reaches the active bank between frames so a frame never mixes values
    copy = pending && (state == IDLE || wrap);
    active_n = copy ? shadow : active;
    blanked = lzb_en && idx_n != '0 && (active_n >> (4 * idx_n)) == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      scan_idx <= '0;
      active <= '0;
      shadow <= '0;
      pending <= 1'b0;
      load_ready <= 1'b1;
      frame_done <= 1'b0;
      digit_en_n <= '1;
      hex_digit <= 4'h0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      scan_idx <= idx_n;
      active <= active_n;
      shadow <= accept ? load_data : shadow;
      pending <= accept | (pending & ~copy);
      load_ready <= accept ? 1'b0 : (load_ready | ~pending);
      frame_done <= wrap;
      digit_en_n <= (state_n == ON && !blanked) ? ~(NUM_DIGITS'(1) << idx_n) : '1;
      hex_digit <= state_n == ON ? active_n[4*idx_n +: 4] : state_n == BLANK ? hex_digit : 4'h0;
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: checks a gapped (BLANK=2) and a gapless (BLANK=0) scanner against a
// frame-position reference model, a slot table, directed corner sequences and random stimulus.
module tb_sevenseg_scan_ctrl;
  localparam int N = 4, ON = 4;

  logic        clk = 1'b0, rst_n = 1'b1, enable = 1'b0, lzb_en = 1'b0, load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        rdy[2], fd[2];
  logic [3:0]  hex[2], den[2];
  logic [1:0]  sidx[2];

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.NUM_DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(2), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lzb_en(lzb_en), .load_valid(load_valid),
    .load_ready(rdy[0]), .load_data(load_data), .hex_digit(hex[0]), .digit_en_n(den[0]),
    .scan_idx(sidx[0]), .frame_done(fd[0]));

  sevenseg_scan_ctrl #(.NUM_DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(0), .IDX_W(2)) dut_nb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lzb_en(lzb_en), .load_valid(load_valid),
    .load_ready(rdy[1]), .load_data(load_data), .hex_digit(hex[1]), .digit_en_n(den[1]),
    .scan_idx(sidx[1]), .frame_done(fd[1]));

  // model: scanning flag, position inside the frame, both banks and the handshake
  bit          m_run[2], m_pend[2], m_rdy[2], m_fd[2];
  int          m_t[2];
  logic [15:0] m_act[2], m_sh[2];

  typedef struct packed {
    logic [15:0] val;
    logic        lzb;
    logic [15:0] den;
    logic [15:0] hx;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_pend[k] = 0; m_rdy[k] = 1; m_fd[k] = 0;
      m_t[k] = 0; m_act[k] = '0; m_sh[k] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int s, p, t;
      bit run, cp, acc;
      s = ON + (k == 0 ? 2 : 0);
      p = N * s;
      if (!enable) begin run = 0; t = 0; end
      else if (!m_run[k]) begin run = 1; t = 0; end
      else begin run = 1; t = (m_t[k] + 1) % p; end
      cp = m_pend[k] && (!m_run[k] || (run && t == 0));
      acc = load_valid && m_rdy[k];
      m_fd[k] = m_run[k] && run && t == 0;
      m_rdy[k] = acc ? 0 : (m_rdy[k] || !m_pend[k]);
      m_pend[k] = acc || (m_pend[k] && !cp);
      if (cp) m_act[k] = m_sh[k];
      if (acc) m_sh[k] = load_data;
      m_run[k] = run;
      m_t[k] = t;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int s, slot, ph;
      bit lit;
      logic [3:0] eh, ed;
      logic [1:0] ei;
      s = ON + (k == 0 ? 2 : 0);
      eh = 4'h0; ed = 4'hF; ei = 2'd0;
      if (m_run[k]) begin
        slot = m_t[k] / s;
        ph = m_t[k] % s;
        ei = slot[1:0];
        eh = 4'(m_act[k] >> (4 * slot));
        lit = ph < ON && !(lzb_en && slot > 0 && (m_act[k] >> (4 * slot)) == 16'h0);
        ed = lit ? 4'(~(4'b0001 << slot)) : 4'hF;
      end
      chk("hex_digit", k, 32'(hex[k]), 32'(eh));
      chk("digit_en_n", k, 32'(den[k]), 32'(ed));
      chk("scan_idx", k, 32'(sidx[k]), 32'(ei));
      chk("frame_done", k, 32'(fd[k]), 32'(m_fd[k]));
      chk("load_ready", k, 32'(rdy[k]), 32'(m_rdy[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic load_idle(input logic [15:0] v);
    enable = 0;
    repeat (3) step();
    load_valid = 1; load_data = v;
    step();
    load_valid = 0;
    repeat (2) step();
  endtask

  task automatic wait_t(input int target, input string name);
    int c;
    for (c = 0; c < 40 && m_t[0] != target; c++) step();
    if (m_t[0] != target) begin
      checks++; errors++;
      $display("FAIL %s: position %0d never reached", name, target);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int first[2], second[2], c;
    logic [15:0] tmp;
    vt[0] = '{16'h1234, 1'b0, 16'h7BDE, 16'h1234};
    vt[1] = '{16'h0070, 1'b1, 16'hFFDE, 16'h0070};
    vt[2] = '{16'h0000, 1'b1, 16'hFFFE, 16'h0000};
    vt[3] = '{16'h0070, 1'b0, 16'h7BDE, 16'h0070};
    vt[4] = '{16'h8001, 1'b1, 16'h7BDE, 16'h8001};
    vt[5] = '{16'h0500, 1'b1, 16'hFBDE, 16'h0500};

    #1 rst_n = 0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_den", k, 32'(den[k]), 32'hF);
      chk("rst_hex", k, 32'(hex[k]), 32'h0);
      chk("rst_idx", k, 32'(sidx[k]), 32'h0);
      chk("rst_ready", k, 32'(rdy[k]), 32'h1);
      chk("rst_fd", k, 32'(fd[k]), 32'h0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step();

    // slot table: digit enables and nibbles seen at the first cycle of each ON slot
    for (int i = 0; i < 6; i++) begin
      lzb_en = vt[i].lzb;
      load_idle(vt[i].val);
      enable = 1;
      step();
      for (int s = 0; s < 4; s++) begin
        tmp = vt[i].den;
        chk("tbl_den", 0, 32'(den[0]), 32'(tmp[4*s +: 4]));
        tmp = vt[i].hx;
        chk("tbl_hex", 0, 32'(hex[0]), 32'(tmp[4*s +: 4]));
        repeat (6) step();
      end
    end

    // frame period of both variants
    lzb_en = 0;
    load_idle(16'h1234);
    enable = 1;
    step();
    first = '{-1, -1};
    second = '{-1, -1};
    for (c = 1; c <= 60; c++) begin
      step();
      for (int k = 0; k < 2; k++)
        if (fd[k] === 1'b1) begin
          if (first[k] < 0) first[k] = c;
          else if (second[k] < 0) second[k] = c;
        end
    end
    chk("frame_period", 0, 32'(second[0] - first[0]), 32'd24);
    chk("frame_period", 1, 32'(second[1] - first[1]), 32'd16);

    // mid-frame load is held back until the wrap
    wait_t(8, "midload_pos");
    load_valid = 1; load_data = 16'hABCD;
    step();
    load_valid = 0;
    chk("ready_drop", 0, 32'(rdy[0]), 32'h0);
    wait_t(0, "midload_wrap");
    chk("hex_after_wrap", 0, 32'(hex[0]), 32'hD);
    chk("ready_at_wrap", 0, 32'(rdy[0]), 32'h0);
    step();
    chk("ready_rise", 0, 32'(rdy[0]), 32'h1);

    // enable dropped two clocks into digit 2
    wait_t(14, "drop_pos");
    enable = 0;
    step();
    chk("drop_den", 0, 32'(den[0]), 32'hF);
    chk("drop_idx", 0, 32'(sidx[0]), 32'h0);
    chk("drop_fd", 0, 32'(fd[0]), 32'h0);
    enable = 1;
    step();
    chk("reen_den", 0, 32'(den[0]), 32'hE);
    chk("reen_hex", 0, 32'(hex[0]), 32'hD);

    // asynchronous reset inside BLANK with a pending shadow
    load_valid = 1; load_data = 16'h5678;
    step();
    load_valid = 0;
    for (c = 0; c < 10 && (m_t[0] % 6) < 4; c++) step();
    chk("pending_before_rst", 0, 32'(rdy[0]), 32'h0);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_den", k, 32'(den[k]), 32'hF);
      chk("arst_hex", k, 32'(hex[k]), 32'h0);
      chk("arst_idx", k, 32'(sidx[k]), 32'h0);
      chk("arst_ready", k, 32'(rdy[k]), 32'h1);
      chk("arst_fd", k, 32'(fd[k]), 32'h0);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    step();
    chk("post_rst_hex", 0, 32'(hex[0]), 32'h0);
    chk("post_rst_den", 0, 32'(den[0]), 32'hE);

    // gapless variant: digit 0 straight to digit 1
    load_idle(16'h1234);
    enable = 1;
    step();
    chk("nb_first", 1, 32'(den[1]), 32'hE);
    repeat (3) step();
    chk("nb_last_on", 1, 32'(den[1]), 32'hE);
    step();
    chk("nb_next", 1, 32'(den[1]), 32'hD);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      enable = $urandom_range(0, 19) != 0;
      if ($urandom_range(0, 49) == 0) lzb_en = ~lzb_en;
      load_valid = $urandom_range(0, 3) == 0;
      load_data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load_data[15:8] = 8'h00;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
